fetch_sequencer: RTL
====================

# fetch_sequencer

Multi-cycle instruction sequencer for the 16-bit core: owns the instruction pointer, instruction register and NZP condition flags, fetches each instruction over a req/ack memory handshake, and dispatches non-control-flow instructions to the execution datapath. It presents `ip`, `ir` and the flags to the existing combinational next-IP unit. It commits that unit's `next_ip` result once per instruction.

## Interface
- `RESET_IP`, 16'h0000, IP value loaded on reset
- `HALT_OP`, 4'b1111, opcode (`ir[15:12]`) that stops the sequencer
- `clk`  in  1  single clock; all state updates on rising edge
- `rst`  in  1  synchronous, active-high reset
- `run`  in  1  level; permits starting a new instruction
- `mem_req`  out  1  instruction fetch request
- `mem_addr`  out  16  fetch address; equals `ip` while `mem_req`=1
- `mem_ack`  in  1  fetch data valid; may assert in the same cycle as `mem_req`
- `mem_rdata`  in  16  instruction word, sampled when `mem_req`&`mem_ack`
- `ip`  out  16  current instruction pointer
- `ir`  out  16  current instruction register
- `flag_n`, `flag_z`, `flag_p`  out  1 each  condition flags
- `next_ip`  in  16  next-IP unit result (computed from `ip`, `ir`, flags)
- `exec_start`  out  1  one-cycle dispatch pulse to datapath
- `exec_done`  in  1  datapath completion strobe
- `wb_valid`  in  1  qualifies `wb_result` as flag-setting; sampled only with `exec_done`
- `wb_result`  in  16  datapath result used to set flags
- `halted`  out  1  high in HALT state
- `retire_cnt`  out  16  instructions retired, wraps 16'hFFFF→0

## Operation
- States: IDLE, FETCH, DECODE, EXEC, UPDATE, HALT.
- Reset values:
  - state IDLE
  - `ip`=RESET_IP
  - `ir`=0
  - flags n,z,p=0,1,0
  - `mem_req`=0
  - `exec_start`=0
  - `halted`=0
  - `retire_cnt`=0
- IDLE: `run`=1 → FETCH; otherwise hold.
- FETCH:
  - Drive `mem_req`=1 and `mem_addr`=`ip`.
  - On `mem_ack`=1, latch `ir`←`mem_rdata` and go to DECODE.
  - `mem_req` is registered low from the next cycle.
- DECODE (exactly 1 cycle):
  - `ir[15:12]`==HALT_OP → HALT.
  - 4'b1100 (BR) or 4'b1101 (JMP) → UPDATE; no dispatch.
  - Otherwise pulse `exec_start` for one cycle → EXEC.
- EXEC:
  - Wait for `exec_done`.
  - If `exec_done`&`wb_valid`: n←`wb_result[15]`, z←(`wb_result`==0), p←!n&!z. Exactly one flag is set.
  - If `exec_done`&!`wb_valid`: flags unchanged.
  - Either way → UPDATE.
- UPDATE (exactly 1 cycle):
  - `ip`←`next_ip` and `retire_cnt`←`retire_cnt`+1.
  - → FETCH if `run`, else IDLE.
  - Flags written in EXEC are already visible here, so branches see up-to-date flags.
- HALT:
  - `halted`=1; `ip`, `ir`, flags and `retire_cnt` frozen.
  - Only `rst` exits.
  - The halt instruction is not retired.
- Boundary rules:
  - `run` deasserted mid-instruction: the instruction completes through UPDATE, then the sequencer parks in IDLE.
  - `mem_ack` outside FETCH: ignored.
  - `exec_done` outside EXEC: ignored.
  - `wb_valid` without `exec_done`: ignored.
  - `rst` in any state, including during a pending fetch or EXEC: the sequencer returns to reset values at that edge. A late `mem_ack` or `exec_done` arriving afterwards is ignored.
  - `ip` wrap: `next_ip` is taken verbatim, so 16'hFFFF→16'h0000 is legal.
  - `retire_cnt` wraps silently.

## Timing
- Zero-wait memory (`mem_ack` in the first FETCH cycle):
  - BR/JMP takes 3 cycles (FETCH, DECODE, UPDATE).
  - ALU instruction with `exec_done` in the first EXEC cycle takes 4 cycles.
- Each memory wait cycle adds 1 cycle; each datapath wait cycle adds 1 cycle.
- Cycle placement:
  - `exec_start` is high in the cycle after DECODE is entered (registered output).
  - `ip` changes in the cycle after UPDATE.
  - `halted` rises in the cycle after DECODE of a halt opcode.
- From IDLE with `run` rising, `mem_req` is high in the following cycle.

## Structure
- Shared package `core_pkg`:
  - state enum
  - opcode constants OP_BR=4'b1100, OP_JMP=4'b1101, OP_HALT=4'b1111
  - 16-bit word typedef
- Sub-module `flag_gen`: combinational `wb_result` → {n,z,p}, reused by the datapath.
- The sequencer FSM, IP/IR/flag registers and retire counter live in `fetch_sequencer`.

## Test plan
- Reset and run with zero-wait memory; `mem_rdata`=16'h1000 (ALU), `exec_done`+`wb_valid` immediate, `wb_result`=16'h8000, `next_ip`=`ip`+1:
  - `mem_addr`=0.
  - n,z,p=1,0,0.
  - `ip`=1 and `retire_cnt`=1 after 4 cycles.
- BR fetch (`mem_rdata`=16'hC805) with the next-IP unit returning 16'h0006: no `exec_start`; `ip`=6 three cycles after the FETCH start.
- Memory stall, `mem_ack` delayed 3 cycles: `mem_req` held high with stable `mem_addr` for 3 cycles; `ir` latched only on ack.
- Halt fetch (`mem_rdata`=16'hF000):
  - `halted`=1.
  - `ip` and `retire_cnt` unchanged over 20 cycles with `run`=1.
  - `rst` restores `ip`=RESET_IP.
- `rst` pulsed during EXEC, then `exec_done` asserted one cycle later: state IDLE, flags 0,1,0, `retire_cnt`=0, and the late `exec_done` is ignored.
- `run` dropped during EXEC: the instruction retires (`retire_cnt`+1) and the sequencer stays in IDLE with `mem_req`=0 until `run` returns. `ip`=16'hFFFF with `next_ip`=0 yields `ip`=0.

Source files
------------

// File: rtl/core_pkg.sv
// Purpose: shared types and constants for the 16-bit core (state enum, opcodes, word type).
// Latency: n/a, declarations only.
// Backpressure: n/a.
package core_pkg;

   typedef logic [15:0] word_t;

   typedef enum logic [2:0] {
      ST_IDLE   = 3'd0,
      ST_FETCH  = 3'd1,
      ST_DECODE = 3'd2,
      ST_EXEC   = 3'd3,
      ST_UPDATE = 3'd4,
      ST_HALT   = 3'd5
   } seq_state_t;

   localparam logic [3:0] OP_BR   = 4'b1100;
   localparam logic [3:0] OP_JMP  = 4'b1101;
   localparam logic [3:0] OP_HALT = 4'b1111;

   localparam word_t RESET_IP_DEFAULT = 16'h0000;

endpackage

// File: rtl/fetch_sequencer_if.sv
// Purpose: bundles the instruction-fetch (req/ack) and datapath dispatch (start/done) handshakes.
// Latency: n/a, wiring only.
// Backpressure: memory stalls by holding mem_ack low; datapath stalls by holding exec_done low.
interface fetch_sequencer_if;
   import core_pkg::*;

   logic  mem_req;
   word_t mem_addr;
   logic  mem_ack;
   word_t mem_rdata;
   logic  exec_start;
   logic  exec_done;
   logic  wb_valid;
   word_t wb_result;

   // Sequencer side
   modport master (
      output mem_req, mem_addr, exec_start,
      input  mem_ack, mem_rdata, exec_done, wb_valid, wb_result
   );

   // Memory / datapath side
   modport slave (
      input  mem_req, mem_addr, exec_start,
      output mem_ack, mem_rdata, exec_done, wb_valid, wb_result
   );

endinterface

// File: rtl/flag_gen.sv
// Purpose: derives the one-hot NZP condition flags from a datapath result word.
// Latency: combinational.
// Backpressure: none.
module flag_gen
   import core_pkg::*;
(
   input  word_t i_result,
   output logic  o_n,
   output logic  o_z,
   output logic  o_p
);

   assign o_n = i_result[15];
   assign o_z = (i_result == 16'h0000);
   // Positive only when neither negative nor zero, so exactly one flag is ever set
   assign o_p = !o_n && !o_z;

endmodule

// File: rtl/fetch_sequencer.sv
// Purpose: multi-cycle fetch/decode/dispatch sequencer owning ip, ir, NZP flags and retire count.
// Latency: 3 cycles for BR/JMP, 4 for ALU ops with zero-wait memory and datapath; +1 per wait cycle.
// Backpressure: holds in FETCH until mem_ack and in EXEC until exec_done; run=0 parks it in IDLE.
module fetch_sequencer
   import core_pkg::*;
#(
   parameter word_t      RESET_IP = RESET_IP_DEFAULT,
   parameter logic [3:0] HALT_OP  = OP_HALT
)
(
   input  logic              i_clk,
   input  logic              i_rst,
   input  logic              i_run,
   fetch_sequencer_if.master bus,
   input  word_t             i_next_ip,
   output word_t             o_ip,
   output word_t             o_ir,
   output logic              o_flag_n,
   output logic              o_flag_z,
   output logic              o_flag_p,
   output logic              o_halted,
   output word_t             o_retire_cnt
);

   seq_state_t r_state;
   word_t      r_ip;
   word_t      r_ir;
   logic       r_flag_n;
   logic       r_flag_z;
   logic       r_flag_p;
   logic       r_mem_req;
   logic       r_exec_start;
   logic       r_halted;
   word_t      r_retire_cnt;

   logic       w_n;
   logic       w_z;
   logic       w_p;
   logic [3:0] w_opcode;

   assign w_opcode = r_ir[15:12];

   flag_gen u_flag_gen (
      .i_result (bus.wb_result),
      .o_n      (w_n),
      .o_z      (w_z),
      .o_p      (w_p)
   );

   // Sequencer FSM; every output is a register so downstream timing is clean
   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         r_state      <= ST_IDLE;
         r_ip         <= RESET_IP;
         r_ir         <= 16'h0000;
         r_flag_n     <= 1'b0;
         r_flag_z     <= 1'b1;
         r_flag_p     <= 1'b0;
         r_mem_req    <= 1'b0;
         r_exec_start <= 1'b0;
         r_halted     <= 1'b0;
         r_retire_cnt <= 16'h0000;
      end else begin
         case (r_state)
            ST_IDLE: begin
               // Raise the request now so it is visible in the first FETCH cycle
               if (i_run) begin
                  r_mem_req <= 1'b1;
                  r_state   <= ST_FETCH;
               end
            end
            ST_FETCH: begin
               if (r_mem_req && bus.mem_ack) begin
                  r_ir      <= bus.mem_rdata;
                  r_mem_req <= 1'b0;
                  r_state   <= ST_DECODE;
               end
            end
            ST_DECODE: begin
               if (w_opcode == HALT_OP) begin
                  r_halted <= 1'b1;
                  r_state  <= ST_HALT;
               end else if (w_opcode == OP_BR || w_opcode == OP_JMP) begin
                  // Control flow is resolved entirely by the next-IP unit
                  r_state <= ST_UPDATE;
               end else begin
                  r_exec_start <= 1'b1;
                  r_state      <= ST_EXEC;
               end
            end
            ST_EXEC: begin
               r_exec_start <= 1'b0;
               if (bus.exec_done) begin
                  if (bus.wb_valid) begin
                     r_flag_n <= w_n;
                     r_flag_z <= w_z;
                     r_flag_p <= w_p;
                  end
                  r_state <= ST_UPDATE;
               end
            end
            ST_UPDATE: begin
               // next_ip is taken verbatim, so 16'hFFFF -> 16'h0000 is a legal step
               r_ip         <= i_next_ip;
               r_retire_cnt <= r_retire_cnt + 16'd1;
               if (i_run) begin
                  r_mem_req <= 1'b1;
                  r_state   <= ST_FETCH;
               end else begin
                  r_state <= ST_IDLE;
               end
            end
            ST_HALT: begin
               // Everything frozen; only reset leaves this state
               r_state <= ST_HALT;
            end
            default: begin
               r_state <= ST_IDLE;
            end
         endcase
      end
   end

   assign bus.mem_req    = r_mem_req;
   assign bus.mem_addr   = r_ip;
   assign bus.exec_start = r_exec_start;

   assign o_ip         = r_ip;
   assign o_ir         = r_ir;
   assign o_flag_n     = r_flag_n;
   assign o_flag_z     = r_flag_z;
   assign o_flag_p     = r_flag_p;
   assign o_halted     = r_halted;
   assign o_retire_cnt = r_retire_cnt;

endmodule
